// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_pkg
//  Brief   : Shared types, constants and the add-3 digit correction used by
//            the sequential binary-to-BCD converter.
//  Rev     : 1.0  initial release
// ============================================================================
package bcd_pkg;

  // Converter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One packed BCD digit
  typedef logic [3:0] digit_t;

  // Saturation value for every digit on overflow
  localparam digit_t BCD_NINE = 4'd9;

  // Double-dabble pre-shift correction: digits of 5 or more get +3 so the
  // following left shift carries correctly into the next decade.
  function automatic digit_t bcd_add3(input digit_t d);
    return (d >= 4'd5) ? digit_t'(d + 4'd3) : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_digit_adj
//  Brief   : Combinational add-3 correction of a single BCD digit.
//  Rev     : 1.0  initial release
// ============================================================================
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  digit_t digit_i,
  output digit_t digit_o
);

  assign digit_o = bcd_add3(digit_i);

endmodule
`default_nettype wire

// File: rtl/bcd_converter_seq.sv
`default_nettype none
// ============================================================================
//  Module  : bcd_converter_seq
//  Brief   : Multi-cycle binary-to-BCD converter (shift-and-add-3, one bit per
//            clock) with valid/ready handshakes, signed input, overflow
//            saturation and a leading-zero blanking mask.
//  Rev     : 1.0  initial release
// ============================================================================
module bcd_converter_seq
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIN_WIDTH-1:0]   bin_in,
  input  logic                   is_signed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*DIGITS-1:0]    bcd_out,
  output logic                   negative,
  output logic                   overflow,
  output logic [DIGITS-1:0]      digit_en
);

  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int DW = 4 * DIGITS;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0]   mag_q, mag_d;
  logic [DW-1:0]          dig_q, dig_d;
  logic                   ovf_q, ovf_d;
  logic                   sign_q, sign_d;
  logic [DW-1:0]          bcd_q, bcd_d;
  logic                   neg_q, neg_d;
  logic                   ovfo_q, ovfo_d;
  logic [DIGITS-1:0]      en_q, en_d;

  logic [DW-1:0]          adj_w;
  logic [DW-1:0]          shift_dig_w;
  logic                   carry_w;
  logic                   ovf_nxt_w;
  logic [DIGITS-1:0]      en_w;

  // Per-digit add-3 correction ahead of each shift
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_i (dig_q[4*gi +: 4]),
        .digit_o (adj_w[4*gi +: 4])
      );
    end
  endgenerate

  // Shift the corrected digits left, pulling in the operand MSB; the bit that
  // leaves the top digit means the value no longer fits in DIGITS decades.
  assign shift_dig_w = {adj_w[DW-2:0], mag_q[BIN_WIDTH-1]};
  assign carry_w     = adj_w[DW-1];
  assign ovf_nxt_w   = ovf_q | carry_w;

  // Blanking mask: a digit is shown if it or any more significant digit is nonzero
  always_comb begin
    logic seen;
    seen = 1'b0;
    en_w = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (|shift_dig_w[4*i +: 4]);
      en_w[i] = seen;
    end
    en_w[0] = 1'b1;
  end

  // Next-state logic for FSM, datapath and result registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovfo_d  = ovfo_q;
    en_d    = en_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          cnt_d   = CW'(BIN_WIDTH);
          dig_d   = '0;
          ovf_d   = 1'b0;
          if (is_signed && bin_in[BIN_WIDTH-1]) begin
            // Unsigned negation keeps the most-negative value exact
            mag_d  = -bin_in;
            sign_d = 1'b1;
          end else begin
            mag_d  = bin_in;
            sign_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        dig_d = shift_dig_w;
        mag_d = {mag_q[BIN_WIDTH-2:0], 1'b0};
        ovf_d = ovf_nxt_w;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          ovfo_d  = ovf_nxt_w;
          neg_d   = sign_q;
          bcd_d   = ovf_nxt_w ? {DIGITS{BCD_NINE}} : shift_dig_w;
          en_d    = ovf_nxt_w ? {DIGITS{1'b1}} : en_w;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      dig_q   <= '0;
      ovf_q   <= 1'b0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovfo_q  <= 1'b0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      dig_q   <= dig_d;
      ovf_q   <= ovf_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovfo_q  <= ovfo_d;
      en_q    <= en_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign bcd_out   = bcd_q;
  assign negative  = neg_q;
  assign overflow  = ovfo_q;
  assign digit_en  = en_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_converter_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_bcd_converter_seq
//  Brief   : Self-checking bench for bcd_converter_seq (default 16b/5 digits
//            and a 4-digit instance) against an arithmetic reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_bcd_converter_seq;

  logic        clk = 1'b0;
  logic        rst_n;

  // Default instance (BIN_WIDTH=16, DIGITS=5)
  logic        in_valid, in_ready, is_signed, out_valid, out_ready;
  logic [15:0] bin_in;
  logic [19:0] bcd_out;
  logic        negative, overflow;
  logic [4:0]  digit_en;

  // Four-digit instance
  logic        iv4, ir4, sg4, ov4, or4;
  logic [15:0] bin4;
  logic [15:0] bcd4;
  logic        neg4, ovf4;
  logic [3:0]  en4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bcd_converter_seq #(.BIN_WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .bcd_out(bcd_out), .negative(negative), .overflow(overflow), .digit_en(digit_en)
  );

  bcd_converter_seq #(.BIN_WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4), .bin_in(bin4), .is_signed(sg4),
    .out_valid(ov4), .out_ready(or4),
    .bcd_out(bcd4), .negative(neg4), .overflow(ovf4), .digit_en(en4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: decimal digits by division, saturation by comparison with 10^d
  function automatic void model(input logic [15:0] b, input bit s, input int d,
                                output logic [19:0] bcd, output logic [4:0] en,
                                output bit neg, output bit ovf);
    longint mag, p;
    int top, dig;
    neg = s && b[15];
    mag = neg ? (65536 - longint'(b)) : longint'(b);
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    ovf = (mag >= p);
    bcd = '0;
    en  = '0;
    top = 0;
    p   = 1;
    for (int i = 0; i < d; i++) begin
      dig = ovf ? 9 : int'((mag / p) % 10);
      bcd[4*i +: 4] = 4'(dig);
      if (dig != 0) top = i;
      p = p * 10;
    end
    for (int i = 0; i <= top; i++) en[i] = 1'b1;
  endfunction

  // One conversion on the default instance
  task automatic conv(input logic [15:0] b, input bit s, input int hold,
                      input bit tie, input bit noise);
    logic [19:0] eb;
    logic [4:0]  ee;
    bit          eneg, eovf;
    int          k;
    model(b, s, 5, eb, ee, eneg, eovf);
    out_ready = tie;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1; bin_in = b; is_signed = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      chk("in_ready_busy", in_ready, 0);
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        bin_in    = 16'($urandom);
        is_signed = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1; k++;
    end
    in_valid = 1'b0;
    chk("latency", k, 16);
    chk("bcd_out", bcd_out, eb);
    chk("digit_en", digit_en, ee);
    chk("negative", negative, eneg);
    chk("overflow", overflow, eovf);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        bin_in   = 16'($urandom);
      end
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_bcd", bcd_out, eb);
      chk("hold_en", digit_en, ee);
      chk("hold_neg", negative, eneg);
    end
    out_ready = 1'b1;
    if (noise) begin
      in_valid = 1'b1;
      bin_in   = 16'($urandom);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = tie;
    chk("post_hs_out_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_bcd_held", bcd_out, eb);
  endtask

  // One conversion on the four-digit instance
  task automatic conv4(input logic [15:0] b);
    logic [19:0] eb;
    logic [4:0]  ee;
    bit          eneg, eovf;
    int          k;
    model(b, 1'b0, 4, eb, ee, eneg, eovf);
    chk("d4_in_ready", ir4, 1);
    iv4 = 1'b1; bin4 = b; sg4 = 1'b0; or4 = 1'b0;
    @(posedge clk); #1;
    iv4 = 1'b0;
    k = 0;
    while (!ov4 && k < 40) begin
      @(posedge clk); #1; k++;
    end
    chk("d4_latency", k, 16);
    chk("d4_bcd", bcd4, eb[15:0]);
    chk("d4_en", en4, ee[3:0]);
    chk("d4_overflow", ovf4, eovf);
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    chk("d4_post_hs_out_valid", ov4, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; bin_in = '0; is_signed = 1'b0; out_ready = 1'b0;
    iv4 = 1'b0; bin4 = '0; sg4 = 1'b0; or4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_en", digit_en, 0);
    chk("rst_neg", negative, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero operand
    conv(16'd0, 1'b0, 0, 1'b0, 1'b0);
    // Back-to-back, out_ready tied high
    conv(16'd1234,  1'b0, 0, 1'b1, 1'b0);
    conv(16'd65535, 1'b0, 0, 1'b1, 1'b0);
    conv(16'd42,    1'b0, 0, 1'b1, 1'b0);
    // Signed mode
    conv(16'hFFD6, 1'b1, 0, 1'b0, 1'b0);
    conv(16'h8000, 1'b1, 0, 1'b0, 1'b0);
    conv(16'h0000, 1'b1, 0, 1'b0, 1'b0);
    conv(16'hFFFF, 1'b1, 1, 1'b0, 1'b0);
    // Four-digit instance: saturation and the largest fitting value
    conv4(16'd12345);
    conv4(16'd9999);
    conv4(16'd10000);
    // Random operands, sign mode, backpressure and input noise
    for (int r = 0; r < 24; r++) begin
      conv(16'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    // Backpressure with ignored input traffic
    conv(16'd305, 1'b0, 5, 1'b0, 1'b1);

    // Reset in the middle of a conversion
    out_ready = 1'b0;
    in_valid = 1'b1; bin_in = 16'd9999; is_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_bcd", bcd_out, 0);
    chk("midrst_en", digit_en, 0);
    chk("midrst_neg", negative, 0);
    chk("midrst_ovf", overflow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("midrst_no_stale_valid", out_valid, 0);
    end
    conv(16'd5678, 1'b0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
